// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the LEGv8 multi-cycle control unit.
//   - state_e   : FSM state encoding (also driven on the debug "state" output)
//   - opcode patterns and don't-care masks for instr[10:0]
//   - AluControl codes, pcSrc encoding, exc_cause encoding
//   - iclass_e  : instruction class produced by mc_opdec
//   - op_match  : masked opcode compare helper
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_EXC    = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      CLS_R       = 3'd0,
      CLS_LDUR    = 3'd1,
      CLS_STUR    = 3'd2,
      CLS_CBZ     = 3'd3,
      CLS_CBNZ    = 3'd4,
      CLS_B       = 3'd5,
      CLS_ILLEGAL = 3'd6
   } iclass_e;

   // Opcode patterns; the masks select the bits that are significant.
   localparam logic [10:0] OP_ADD    = 11'b10001011000;
   localparam logic [10:0] OP_SUB    = 11'b11001011000;
   localparam logic [10:0] OP_AND    = 11'b10001010000;
   localparam logic [10:0] OP_ORR    = 11'b10101010000;
   localparam logic [10:0] OP_LDUR   = 11'b11111000010;
   localparam logic [10:0] OP_STUR   = 11'b11111000000;
   localparam logic [10:0] OP_CBZ    = 11'b10110100000;
   localparam logic [10:0] OP_CBNZ   = 11'b10110101000;
   localparam logic [10:0] OP_B      = 11'b00010100000;
   localparam logic [10:0] MASK_FULL = 11'b11111111111;
   localparam logic [10:0] MASK_CB   = 11'b11111111000;
   localparam logic [10:0] MASK_B    = 11'b11111100000;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [1:0] PC_SRC_SEQ = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_EXC = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
   localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

   function automatic logic op_match(input logic [10:0] op,
                                     input logic [10:0] pat,
                                     input logic [10:0] mask);
      return ((op ^ pat) & mask) == 11'd0;
   endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: bundle between the control unit and the datapath / memories.
//   Parameter OPW : opcode field width (IR[31:21]).
//   master modport: the control unit (takes instr/zero/readies, drives controls).
//   slave  modport: the datapath side.
//
// Handshake: imem_req, memRead and memWrite are requests. Once raised, a
// request stays high on every cycle until the matching ready (imem_ready or
// dmem_ready) is sampled high on a rising clock edge; the transfer completes
// on that edge and the request drops in the following cycle. Ready seen while
// no request is up is ignored.
interface mc_if #(
   parameter int OPW = 11
);
   logic [OPW-1:0] instr;
   logic           zero;
   logic           imem_ready;
   logic           dmem_ready;
   logic           imem_req;
   logic           irWrite;
   logic           pcWrite;
   logic [1:0]     pcSrc;
   logic           reg2loc;
   logic           AluSrc;
   logic           memtoReg;
   logic           regWrite;
   logic           memRead;
   logic           memWrite;
   logic [3:0]     AluControl;
   logic [2:0]     state;
   logic           exc;
   logic [1:0]     exc_cause;

   modport master (
      input  instr, zero, imem_ready, dmem_ready,
      output imem_req, irWrite, pcWrite, pcSrc, reg2loc, AluSrc, memtoReg,
             regWrite, memRead, memWrite, AluControl, state, exc, exc_cause
   );

   modport slave (
      output instr, zero, imem_ready, dmem_ready,
      input  imem_req, irWrite, pcWrite, pcSrc, reg2loc, AluSrc, memtoReg,
             regWrite, memRead, memWrite, AluControl, state, exc, exc_cause
   );
endinterface

// File: rtl/mc_opdec.sv
// mc_opdec: combinational opcode classifier.
//   instr    in  11  opcode field
//   iclass   out     instruction class (CLS_ILLEGAL when nothing matches)
//   alu_ctrl out 4   ALU operation for the EXEC step of that class
module mc_opdec
   import mc_pkg::*;
(
   input  logic [10:0] instr,
   output iclass_e     iclass,
   output logic [3:0]  alu_ctrl
);

   always_comb begin
      iclass   = CLS_ILLEGAL;
      alu_ctrl = ALU_AND;
      if (op_match(instr, OP_ADD, MASK_FULL)) begin
         iclass   = CLS_R;
         alu_ctrl = ALU_ADD;
      end else if (op_match(instr, OP_SUB, MASK_FULL)) begin
         iclass   = CLS_R;
         alu_ctrl = ALU_SUB;
      end else if (op_match(instr, OP_AND, MASK_FULL)) begin
         iclass   = CLS_R;
         alu_ctrl = ALU_AND;
      end else if (op_match(instr, OP_ORR, MASK_FULL)) begin
         iclass   = CLS_R;
         alu_ctrl = ALU_ORR;
      end else if (op_match(instr, OP_LDUR, MASK_FULL)) begin
         iclass   = CLS_LDUR;
         alu_ctrl = ALU_ADD;
      end else if (op_match(instr, OP_STUR, MASK_FULL)) begin
         iclass   = CLS_STUR;
         alu_ctrl = ALU_ADD;
      end else if (op_match(instr, OP_CBZ, MASK_CB)) begin
         iclass   = CLS_CBZ;
         alu_ctrl = ALU_PASSB;
      end else if (op_match(instr, OP_CBNZ, MASK_CB)) begin
         iclass   = CLS_CBNZ;
         alu_ctrl = ALU_PASSB;
      end else if (op_match(instr, OP_B, MASK_B)) begin
         iclass   = CLS_B;
         alu_ctrl = ALU_AND;
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: LEGv8 multi-cycle control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath mux/enable.
//   Parameter TIMEOUT : memory wait limit in cycles (>= 2)
//   clk   in  rising-edge clock
//   reset in  asynchronous, active-low reset
//   bus   mc_if.master: instr/zero/imem_ready/dmem_ready in; all controls,
//         debug state, exc and exc_cause out
// Build option: define MC_EXCEPTION_EN to enable the EXC state (illegal
// opcode and memory timeout faults). Without it an illegal opcode is a NOP,
// memory waits are unbounded, exc=0 and exc_cause=00.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input logic  clk,
   input logic  reset,
   mc_if.master bus
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    cause_q, cause_d;

   iclass_e       iclass;
   logic [3:0]    alu_dec;
   logic          cnt_done;

   logic          imem_req, ir_write, pc_write, reg2loc, alu_src;
   logic          memto_reg, reg_write, mem_read, mem_write, exc;
   logic [1:0]    pc_src;
   logic [3:0]    alu_ctrl;

   mc_opdec u_opdec (
      .instr    (bus.instr),
      .iclass   (iclass),
      .alu_ctrl (alu_dec)
   );

   assign cnt_done = (cnt_q == CNT_LAST);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         ST_FETCH: begin
            if (bus.imem_ready) begin
               state_d = ST_DECODE;
            end
`ifdef MC_EXCEPTION_EN
            else if (cnt_done) begin
               state_d = ST_EXC;
               cause_d = CAUSE_IMEM_TO;
            end
`endif
         end
         ST_DECODE: begin
            if (iclass == CLS_ILLEGAL) begin
`ifdef MC_EXCEPTION_EN
               state_d = ST_EXC;
               cause_d = CAUSE_ILLEGAL;
`else
               state_d = ST_FETCH;
`endif
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (iclass)
               CLS_R:              state_d = ST_WB;
               CLS_LDUR, CLS_STUR: state_d = ST_MEM;
               default:            state_d = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (bus.dmem_ready) begin
               state_d = (iclass == CLS_LDUR) ? ST_WB : ST_FETCH;
            end
`ifdef MC_EXCEPTION_EN
            else if (cnt_done) begin
               state_d = ST_EXC;
               cause_d = CAUSE_DMEM_TO;
            end
`endif
         end
         ST_WB:   state_d = ST_FETCH;
         default: state_d = ST_FETCH;
      endcase
   end

   // Wait counter: zero whenever we are not lingering in FETCH/MEM, so each
   // entry into a wait state starts from 0. It saturates at TIMEOUT-1, which
   // is what keeps the macro-off build waiting forever without wrapping.
   always_comb begin
      cnt_d = '0;
      if ((state_q == ST_FETCH || state_q == ST_MEM) && state_d == state_q) begin
         cnt_d = cnt_done ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   // Output decode from state and instr; zero only affects pcWrite in EXEC.
   always_comb begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_SEQ;
      reg2loc   = 1'b0;
      alu_src   = 1'b0;
      memto_reg = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      alu_ctrl  = ALU_AND;
      exc       = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
            // Held in reset the FSM sits in FETCH; keep the loads off there.
            if (bus.imem_ready && reset) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         ST_EXEC: begin
            alu_ctrl = alu_dec;
            case (iclass)
               CLS_LDUR, CLS_STUR: alu_src = 1'b1;
               CLS_CBZ: begin
                  reg2loc  = 1'b1;
                  pc_src   = PC_SRC_BR;
                  pc_write = bus.zero;
               end
               CLS_CBNZ: begin
                  reg2loc  = 1'b1;
                  pc_src   = PC_SRC_BR;
                  pc_write = !bus.zero;
               end
               CLS_B: begin
                  pc_src   = PC_SRC_BR;
                  pc_write = 1'b1;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            mem_read  = (iclass == CLS_LDUR);
            mem_write = (iclass == CLS_STUR);
         end
         ST_WB: begin
            reg_write = 1'b1;
            memto_reg = (iclass == CLS_LDUR);
         end
`ifdef MC_EXCEPTION_EN
         ST_EXC: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_EXC;
            exc      = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign bus.imem_req   = imem_req;
   assign bus.irWrite    = ir_write;
   assign bus.pcWrite    = pc_write;
   assign bus.pcSrc      = pc_src;
   assign bus.reg2loc    = reg2loc;
   assign bus.AluSrc     = alu_src;
   assign bus.memtoReg   = memto_reg;
   assign bus.regWrite   = reg_write;
   assign bus.memRead    = mem_read;
   assign bus.memWrite   = mem_write;
   assign bus.AluControl = alu_ctrl;
   assign bus.state      = state_q;
   assign bus.exc        = exc;
   assign bus.exc_cause  = cause_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: cycle-accurate bench for multicycle_controller.
// Each instruction is expanded into its expected per-cycle trace (inputs to
// drive plus the full expected output vector) from the instruction rules,
// then replayed against the DUT. Build with or without MC_EXCEPTION_EN.
module tb_multicycle_controller;
   import mc_pkg::*;

   localparam int TIMEOUT = 16;
`ifdef MC_EXCEPTION_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif

   localparam int C_R    = 0;
   localparam int C_LD   = 1;
   localparam int C_ST   = 2;
   localparam int C_CBZ  = 3;
   localparam int C_CBNZ = 4;
   localparam int C_B    = 5;
   localparam int C_ILL  = 6;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mc_if #(.OPW(11)) bus ();

   multicycle_controller #(.TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- expected trace ----------------
   typedef struct packed {
      logic [2:0] st;
      logic       req, irw, pcw;
      logic [1:0] src;
      logic       r2l, asrc, m2r, rw, mr, mw;
      logic [3:0] alu;
      logic       exc;
      logic [1:0] cause;
   } ov_t;

   typedef struct packed {
      logic [10:0] instr;
      logic        imem_ready, dmem_ready, zero;
      ov_t         ov;
   } cyc_t;

   cyc_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [1:0] model_cause;

   logic [10:0] r_op  [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
   logic [3:0]  r_alu [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s t=%0t observed %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic ov_t observe();
      ov_t o;
      o.st    = bus.state;
      o.req   = bus.imem_req;
      o.irw   = bus.irWrite;
      o.pcw   = bus.pcWrite;
      o.src   = bus.pcSrc;
      o.r2l   = bus.reg2loc;
      o.asrc  = bus.AluSrc;
      o.m2r   = bus.memtoReg;
      o.rw    = bus.regWrite;
      o.mr    = bus.memRead;
      o.mw    = bus.memWrite;
      o.alu   = bus.AluControl;
      o.exc   = bus.exc;
      o.cause = bus.exc_cause;
      return o;
   endfunction

   function automatic ov_t base(input logic [2:0] st);
      ov_t o = '0;
      o.st    = st;
      o.cause = model_cause;
      return o;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit is_legal(input logic [10:0] op);
      return (op inside {11'b10001011000, 11'b11001011000, 11'b10001010000,
                         11'b10101010000, 11'b11111000010, 11'b11111000000})
             || (op[10:3] == 8'b10110100) || (op[10:3] == 8'b10110101)
             || (op[10:5] == 6'b000101);
   endfunction

   task automatic push(input logic [10:0] op, input logic ir, input logic dr,
                       input logic z, input ov_t o);
      cyc_t c;
      c.instr      = op;
      c.imem_ready = ir;
      c.dmem_ready = dr;
      c.zero       = z;
      c.ov         = o;
      exp_q.push_back(c);
   endtask

   task automatic raise(input logic [10:0] op, input logic [1:0] cause);
      ov_t o;
      model_cause = cause;
      o      = base(3'(ST_EXC));
      o.pcw  = 1'b1;
      o.src  = 2'b10;
      o.exc  = 1'b1;
      push(op, rbit(), rbit(), rbit(), o);
   endtask

   // Expand one instruction: di/dm = ready delays, zsel<0 = random zero.
   task automatic gen_instr(input int cls, input logic [10:0] op, input logic [3:0] ralu,
                            input int di, input int dm, input int zsel);
      ov_t  o;
      logic z;
      for (int k = 0; k <= di; k++) begin
         if (EXC_EN && k == TIMEOUT) begin
            raise(11'($urandom_range(0, 2047)), 2'b10);
            return;
         end
         o     = base(3'(ST_FETCH));
         o.req = 1'b1;
         if (k == di) begin
            o.irw = 1'b1;
            o.pcw = 1'b1;
         end
         push(11'($urandom_range(0, 2047)), k == di, rbit(), rbit(), o);
      end
      push(op, rbit(), rbit(), rbit(), base(3'(ST_DECODE)));
      if (cls == C_ILL) begin
         if (EXC_EN) raise(op, 2'b01);
         return;
      end
      z = (zsel < 0) ? rbit() : zsel[0];
      o = base(3'(ST_EXEC));
      case (cls)
         C_R: o.alu = ralu;
         C_LD, C_ST: begin
            o.asrc = 1'b1;
            o.alu  = 4'b0010;
         end
         C_CBZ, C_CBNZ: begin
            o.r2l = 1'b1;
            o.alu = 4'b0111;
            o.src = 2'b01;
            o.pcw = (cls == C_CBZ) ? z : !z;
         end
         default: begin
            o.src = 2'b01;
            o.pcw = 1'b1;
         end
      endcase
      push(op, rbit(), rbit(), z, o);
      if (cls >= C_CBZ) return;
      if (cls == C_LD || cls == C_ST) begin
         for (int k = 0; k <= dm; k++) begin
            if (EXC_EN && k == TIMEOUT) begin
               raise(op, 2'b11);
               return;
            end
            o    = base(3'(ST_MEM));
            o.mr = (cls == C_LD);
            o.mw = (cls == C_ST);
            push(op, rbit(), k == dm, rbit(), o);
         end
         if (cls == C_ST) return;
      end
      o     = base(3'(ST_WB));
      o.rw  = 1'b1;
      o.m2r = (cls == C_LD);
      push(op, rbit(), rbit(), rbit(), o);
   endtask

   task automatic gen_class(input int cls, input int di, input int dm, input int zsel);
      logic [10:0] op;
      logic [3:0]  ralu;
      int          sel;
      sel  = $urandom_range(0, 3);
      ralu = r_alu[sel];
      case (cls)
         C_R:    op = r_op[sel];
         C_LD:   op = 11'b11111000010;
         C_ST:   op = 11'b11111000000;
         C_CBZ:  op = {8'b10110100, 3'($urandom_range(0, 7))};
         C_CBNZ: op = {8'b10110101, 3'($urandom_range(0, 7))};
         C_B:    op = {6'b000101, 5'($urandom_range(0, 31))};
         default: begin
            op = 11'($urandom_range(0, 2047));
            while (is_legal(op)) op = 11'($urandom_range(0, 2047));
         end
      endcase
      gen_instr(cls, op, ralu, di, dm, zsel);
   endtask

   // Replay up to n queued cycles (n<0: all). Entered at a falling edge.
   task automatic run_q(input int n);
      cyc_t c;
      ov_t  o;
      int   k = 0;
      while (exp_q.size() > 0 && (n < 0 || k < n)) begin
         c = exp_q.pop_front();
         bus.instr      = c.instr;
         bus.imem_ready = c.imem_ready;
         bus.dmem_ready = c.dmem_ready;
         bus.zero       = c.zero;
         #2;
         o = observe();
         check("state", 32'(o.st), 32'(c.ov.st));
         check("ctrl", 32'(o), 32'(c.ov));
         k++;
         @(negedge clk);
      end
   endtask

   function automatic int rand_delay();
      if ($urandom_range(0, 9) == 0) return $urandom_range(TIMEOUT - 3, TIMEOUT + 2);
      return $urandom_range(0, 3);
   endfunction

   // ---------------- main sequence ----------------
   ov_t rst_exp;

   initial begin
      reset          = 1'b0;
      bus.instr      = '0;
      bus.zero       = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      model_cause    = 2'b00;
      rst_exp        = '0;
      rst_exp.st     = 3'(ST_FETCH);
      rst_exp.req    = 1'b1;

      repeat (2) @(negedge clk);
      check("reset_state", 32'(observe()), 32'(rst_exp));
      bus.imem_ready = 1'b1;
      #1;
      check("reset_rdy", 32'(observe()), 32'(rst_exp));
      bus.imem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Directed cases
      gen_class(C_R,    0, 0, -1);          run_q(-1);
      gen_class(C_LD,   0, 3, -1);          run_q(-1);
      gen_class(C_ST,   0, 0, -1);          run_q(-1);
      gen_class(C_CBNZ, 0, 0, 0);           run_q(-1);
      gen_class(C_CBNZ, 0, 0, 1);           run_q(-1);
      gen_class(C_CBZ,  0, 0, 1);           run_q(-1);
      gen_class(C_CBZ,  0, 0, 0);           run_q(-1);
      gen_class(C_B,    0, 0, -1);          run_q(-1);
      gen_instr(C_ILL, 11'b00000000000, 4'b0000, 0, 0, -1); run_q(-1);
      gen_class(C_R,    TIMEOUT + 4, 0, -1); run_q(-1);
      gen_class(C_R,    TIMEOUT - 1, 0, -1); run_q(-1);
      gen_class(C_LD,   1, TIMEOUT - 1, -1); run_q(-1);
      gen_class(C_ST,   0, TIMEOUT, -1);     run_q(-1);
      gen_class(C_LD,   2, TIMEOUT + 3, -1); run_q(-1);

      // Randomized instruction stream
      for (int i = 0; i < 300; i++) begin
         gen_class($urandom_range(0, 6), rand_delay(), rand_delay(), -1);
         run_q(-1);
      end

      // Reset in the middle of a STUR memory wait
      gen_instr(C_ILL, 11'b00000000000, 4'b0000, 0, 0, -1); run_q(-1);
      gen_class(C_ST, 0, 8, -1);
      run_q(5);
      check("pre_rst_mw", 32'(bus.memWrite), 32'd1);
      reset = 1'b0;
      #1;
      model_cause = 2'b00;
      check("rst_abort", 32'(observe()), 32'(rst_exp));
      exp_q.delete();
      bus.imem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      gen_class(C_R, 0, 0, -1); run_q(-1);
      for (int i = 0; i < 20; i++) begin
         gen_class($urandom_range(0, 6), rand_delay(), rand_delay(), -1);
         run_q(-1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t checks %0d", $time, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control unit for the LEGv8 datapath. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and replaces the single-cycle decoder pair, so instruction and data memory can share slow, handshaked ports. Adds CBNZ and B, variable-latency memory waits with a timeout, and an optional illegal-opcode/timeout exception path. Sits between the instruction register and all datapath muxes/enables.

## Interface
- OPW, 11, opcode field width taken from IR[31:21]
- TIMEOUT, 16, max cycles waited on a memory ready before a timeout fault (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instr  in  OPW  opcode field, stable from DECODE until the next FETCH
- zero  in  1  ALU zero flag, valid in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- irWrite, pcWrite  out  1  IR / PC load enables
- pcSrc  out  2  00 PC+4, 01 branch target, 10 exception vector
- reg2loc, AluSrc, memtoReg, regWrite, memRead, memWrite  out  1  datapath controls, same meaning as the single-cycle set
- AluControl  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
- state  out  3  current state (debug)
- exc  out  1  one-cycle exception pulse (macro only, else tied 0)
- exc_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout; sticky until reset

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, EXC.
- FETCH: imem_req=1. On imem_ready: irWrite=1, pcWrite=1, pcSrc=00, → DECODE.
- DECODE: classify instr. Legal → EXEC. Illegal → EXC (macro) or FETCH as NOP.
- EXEC:
  - R-type: AluSrc=0, reg2loc=0; → WB.
  - LDUR/STUR: AluSrc=1, ADD; → MEM.
  - CBZ/CBNZ: reg2loc=1, pass-B. pcWrite=zero (CBZ) or !zero (CBNZ), pcSrc=01; → FETCH.
  - B: pcWrite=1, pcSrc=01; → FETCH.
- MEM: memRead (LDUR) or memWrite (STUR) held until dmem_ready. Then LDUR → WB, STUR → FETCH.
- WB: regWrite=1, memtoReg=1 for LDUR else 0; → FETCH.
- EXC: pcWrite=1, pcSrc=10, exc=1; → FETCH.
- Timeout counter: clears on entry to FETCH/MEM and counts waiting cycles. On reaching TIMEOUT-1 without ready:
  - macro on: → EXC with cause 10/11;
  - macro off: counter saturates and the FSM keeps waiting.
- Ready on the same cycle as the timeout wins: normal transition, no fault.
- Control outputs are decoded from state and instr. Only pcWrite in EXEC depends on zero.
- Opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, CBNZ 10110101xxx, B 000101xxxxx.

## Timing
- Reset (async assert, sync release):
  - state=FETCH, counter=0, exc_cause=00;
  - imem_req=1, all other outputs 0.
- Zero-wait latency: R-type 4 cycles, LDUR 5, STUR 4, CBZ/CBNZ/B 3, illegal 3 (macro) / 2.
- Each memory wait cycle adds one cycle.
- A request stays asserted until its ready is seen. Ready is sampled on the clock edge.
- Reset mid-instruction aborts it with no pending write enable: the next active cycle is FETCH.

## Configuration
- MC_EXCEPTION_EN defined: EXC state reachable; exc and exc_cause functional.
- Undefined: EXC state not synthesised. Illegal opcode is a NOP, memory waits have no limit, exc=0, exc_cause=00.

## Structure
- Package mc_pkg:
  - state enum;
  - opcode constants and masks;
  - AluControl codes;
  - pcSrc encoding;
  - exc_cause encoding;
  - instruction-class enum (R, LDUR, STUR, CBZ, CBNZ, B, ILLEGAL).
- Sub-module mc_opdec: combinational, instr → class and AluControl.
- multicycle_controller holds the FSM, timeout counter and output decode.

## Test plan
- ADD (10001011000), zero-wait → FETCH,DECODE,EXEC,WB. regWrite=1 only in WB, AluControl=0010 in EXEC.
- LDUR with dmem_ready delayed 3 cycles → memRead held 4 MEM cycles, then WB with memtoReg=1. Total 8 cycles.
- CBNZ with zero=0 → pcWrite=1, pcSrc=01 in EXEC. Same with zero=1 → pcWrite=0. Both 3 cycles.
- Opcode 00000000000 → with macro: EXC, pcSrc=10, exc pulse, exc_cause=01. Without macro: back to FETCH, no writes.
- imem_ready held 0, TIMEOUT=16 → with macro: EXC after 16 FETCH cycles, exc_cause=10. Without macro: imem_req held indefinitely.
- reset pulled low during MEM of STUR → memWrite drops immediately. After release: state=FETCH, exc_cause=00.
